// File: rtl/pixel_preprocessor.sv
// Pixel preprocessor: per-channel mean subtract, scale, shift and saturate an
// interleaved HWC byte stream, writing signed results in planar CHW order.
module pixel_preprocessor #(
    parameter int unsigned IMAGE_WIDTH  = 224,
    parameter int unsigned IMAGE_HEIGHT = 224,
    parameter int unsigned MEAN_R       = 124,
    parameter int unsigned MEAN_G       = 116,
    parameter int unsigned MEAN_B       = 104,
    parameter int unsigned SCALE        = 1,
    parameter int unsigned SHIFT        = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic [19:0] in_addr,
    input  logic        in_we,
    output logic [7:0]  out_data,
    output logic [19:0] out_addr,
    output logic        out_we,
    output logic        busy,
    output logic        done,
    output logic        seq_err
);

    localparam logic [19:0] PLANE  = 20'(IMAGE_WIDTH * IMAGE_HEIGHT);
    localparam logic [19:0] TOTAL  = 20'(3 * IMAGE_WIDTH * IMAGE_HEIGHT);
    localparam logic [19:0] BASE_B = 20'(2 * IMAGE_WIDTH * IMAGE_HEIGHT);
    localparam logic [7:0]  MR     = 8'(MEAN_R);
    localparam logic [7:0]  MG     = 8'(MEAN_G);
    localparam logic [7:0]  MB     = 8'(MEAN_B);
    localparam logic [7:0]  SC     = 8'(SCALE);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t             state, state_nxt;
    logic [1:0]         ch;
    logic [19:0]        pos;
    logic [19:0]        cnt;
    logic               drain_cnt;
    logic               accept;
    logic               last_byte;
    logic [7:0]         mean_sel;
    logic [19:0]        base_sel;
    logic signed [8:0]  diff;
    logic signed [17:0] prod;
    logic               s1_valid;
    logic signed [17:0] s1_prod;
    logic [19:0]        s1_addr;
    logic signed [17:0] sh;
    logic [7:0]         sat;

    assign accept    = (state == ST_RUN) && in_we;
    assign last_byte = accept && (cnt == TOTAL - 20'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (last_byte) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_cnt) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN) || (state == ST_DRAIN);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch        <= '0;
            pos       <= '0;
            cnt       <= '0;
            drain_cnt <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
            if (state == ST_IDLE && start) begin
                ch      <= '0;
                pos     <= '0;
                cnt     <= '0;
                seq_err <= 1'b0;
            end else begin
                if (accept) begin
                    cnt <= cnt + 20'd1;
                    if (ch == 2'd2) begin
                        ch  <= '0;
                        pos <= pos + 20'd1;
                    end else begin
                        ch <= ch + 2'd1;
                    end
                end
                // Out-of-order bytes are still processed; late bytes are dropped.
                if ((accept && in_addr != cnt) ||
                    ((state == ST_DRAIN || state == ST_DONE) && in_we))
                    seq_err <= 1'b1;
            end
        end
    end

    always_comb begin
        case (ch)
            2'd0:    begin mean_sel = MR; base_sel = '0;     end
            2'd1:    begin mean_sel = MG; base_sel = PLANE;  end
            default: begin mean_sel = MB; base_sel = BASE_B; end
        endcase
        diff = $signed({1'b0, in_data}) - $signed({1'b0, mean_sel});
        prod = $signed({{9{diff[8]}}, diff}) * $signed({10'b0, SC});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_prod <= prod;
                s1_addr <= base_sel + pos;
            end
        end
    end

    always_comb begin
        sh = s1_prod >>> SHIFT;
        if (sh > 18'sd127)       sat = 8'h7F;
        else if (sh < -18'sd128) sat = 8'h80;
        else                     sat = sh[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_we   <= 1'b0;
            out_data <= '0;
            out_addr <= '0;
        end else begin
            out_we <= s1_valid;
            if (s1_valid) begin
                out_data <= sat;
                out_addr <= s1_addr;
            end
        end
    end

endmodule

// File: tb/tb_pixel_preprocessor.sv
// Bench for pixel_preprocessor: three instances (SCALE 1, SCALE 4, SCALE 3/SHIFT 2)
// share one stimulus stream and are checked every cycle against a behavioural model.
module tb_pixel_preprocessor;

    logic        clk = 1'b0;
    logic        rst, start, in_we;
    logic [7:0]  in_data;
    logic [19:0] in_addr;

    logic [7:0]  od_a, od_b, od_c;
    logic [19:0] oa_a, oa_b, oa_c;
    logic        ow_a, ow_b, ow_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic        err_a, err_b, err_c;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pixel_preprocessor #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(2), .MEAN_R(128), .MEAN_G(128),
                         .MEAN_B(128), .SCALE(1), .SHIFT(0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_addr(in_addr),
        .in_we(in_we), .out_data(od_a), .out_addr(oa_a), .out_we(ow_a),
        .busy(busy_a), .done(done_a), .seq_err(err_a));

    pixel_preprocessor #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(2), .MEAN_R(128), .MEAN_G(128),
                         .MEAN_B(128), .SCALE(4), .SHIFT(0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_addr(in_addr),
        .in_we(in_we), .out_data(od_b), .out_addr(oa_b), .out_we(ow_b),
        .busy(busy_b), .done(done_b), .seq_err(err_b));

    pixel_preprocessor #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(2), .MEAN_R(128), .MEAN_G(128),
                         .MEAN_B(128), .SCALE(3), .SHIFT(2)) dut_c (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_addr(in_addr),
        .in_we(in_we), .out_data(od_c), .out_addr(oa_c), .out_we(ow_c),
        .busy(busy_c), .done(done_c), .seq_err(err_c));

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp)
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    // Reference arithmetic: signed difference, scale, arithmetic shift, clamp.
    function automatic int model_px(input int d, input int scale, input int shift);
        int v;
        v = ((d - 128) * scale) >>> shift;
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    // Model: mode 0 idle, 1 accepting, 2 finished image (drain + done window).
    int cyc = 0;
    int mode = 0, mcnt = 0, merr = 0, last_e = -100;
    int exp_busy = 0, exp_done = 0, exp_err = 0;
    int exp_addr[int], exp_d1[int], exp_d4[int], exp_d3[int];

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            mode = 0; mcnt = 0; merr = 0; last_e = -100;
            exp_addr.delete(); exp_d1.delete(); exp_d4.delete(); exp_d3.delete();
        end else begin
            if (mode == 2 && cyc > last_e + 3) mode = 0;
            case (mode)
                0: if (start) begin mode = 1; mcnt = 0; merr = 0; end
                1: if (in_we) begin
                    if (int'(in_addr) != mcnt) merr = 1;
                    exp_addr[cyc + 1] = (mcnt % 3) * 8 + mcnt / 3;
                    exp_d1[cyc + 1]   = model_px(int'(in_data), 1, 0);
                    exp_d4[cyc + 1]   = model_px(int'(in_data), 4, 0);
                    exp_d3[cyc + 1]   = model_px(int'(in_data), 3, 2);
                    mcnt++;
                    if (mcnt == 24) begin mode = 2; last_e = cyc; end
                end
                default: if (in_we) merr = 1;
            endcase
        end
        exp_busy = (rst && (mode == 1 || (mode == 2 && cyc <= last_e + 1))) ? 1 : 0;
        exp_done = (rst && mode == 2 && cyc == last_e + 2) ? 1 : 0;
        exp_err  = rst ? merr : 0;
    end

    int first_in = -1, first_out = -1, last_out = -1, done_cyc = -1, done_cnt = 0, we_cnt = 0;
    int mem1[24], mem4[24], mem3[24];

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_out_we", int'(ow_a), 0);
            chk("rst_out_data", int'(od_a), 0);
            chk("rst_out_addr", int'(oa_a), 0);
            chk("rst_busy", int'(busy_a), 0);
            chk("rst_done", int'(done_a), 0);
            chk("rst_seq_err", int'(err_a), 0);
        end else begin
            int we;
            we = exp_addr.exists(cyc) ? 1 : 0;
            chk("out_we", int'(ow_a), we);
            chk("out_we_s4", int'(ow_b), we);
            chk("out_we_s3", int'(ow_c), we);
            if (we == 1) begin
                chk("out_addr", int'(oa_a), exp_addr[cyc]);
                chk("out_addr_s4", int'(oa_b), exp_addr[cyc]);
                chk("out_addr_s3", int'(oa_c), exp_addr[cyc]);
                chk("out_data", int'($signed(od_a)), exp_d1[cyc]);
                chk("out_data_s4", int'($signed(od_b)), exp_d4[cyc]);
                chk("out_data_s3", int'($signed(od_c)), exp_d3[cyc]);
                exp_addr.delete(cyc); exp_d1.delete(cyc); exp_d4.delete(cyc); exp_d3.delete(cyc);
            end
            chk("busy", int'(busy_a), exp_busy);
            chk("done", int'(done_a), exp_done);
            chk("seq_err", int'(err_a), exp_err);
            if (ow_a) begin
                we_cnt++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                if (oa_a < 20'd24) begin
                    mem1[oa_a] = int'($signed(od_a));
                    mem4[oa_a] = int'($signed(od_b));
                    mem3[oa_a] = int'($signed(od_c));
                end
            end
            if (done_a) begin done_cnt++; done_cyc = cyc; end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] data_for(input int dmode, input int k);
        int v;
        v = k;
        if (dmode == 1) v = int'($urandom_range(0, 255));
        if (dmode == 2) begin
            case (k)
                0: v = 0;   1: v = 128; 2: v = 255;
                3: v = 200; 4: v = 20;  5: v = 140;
                default: v = k;
            endcase
        end
        return 8'(v);
    endfunction

    // gap_mode: 0 dense, 1 alternate idle cycles, 2 random gaps.
    task automatic run_image(input int gap_mode, input int dmode, input int skip_from,
                             input bit extra, input int nbytes);
        int n;
        first_in = -1; first_out = -1; last_out = -1; done_cyc = -1; done_cnt = 0; we_cnt = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        in_we = 1'b0;
        chk("start_clears_seq_err", int'(err_a), 0);
        for (int k = 0; k < nbytes; k++) begin
            if (gap_mode == 2) begin
                while ($urandom_range(0, 2) == 0) tick;
            end
            in_we   = 1'b1;
            in_data = data_for(dmode, k);
            in_addr = (skip_from >= 0 && k >= skip_from) ? 20'(k + 1) : 20'(k);
            if (first_in < 0) first_in = cyc;
            tick;
            in_we = 1'b0;
            if (gap_mode == 1) tick;
        end
        if (nbytes < 24) return;
        if (extra) begin
            in_we = 1'b1; in_data = 8'd77; in_addr = 20'd24;
            tick;
            in_we = 1'b0;
        end
        n = 0;
        while (!done_a && n < 12) begin tick; n++; end
        if (!done_a) chk("done_timeout", 0, 1);
        tick;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; in_we = 1'b0; in_data = '0; in_addr = '0;
        repeat (3) tick;
        rst = 1'b1;
        tick;

        // Dense image, data = index.
        run_image(0, 0, -1, 1'b0, 24);
        chk("s1_first_latency", first_out - first_in, 2);
        chk("s1_done_after_last", done_cyc - last_out, 1);
        chk("s1_done_count", done_cnt, 1);
        chk("s1_addr9_data", mem1[9], -124);
        chk("s1_addr23_data", mem1[23], -105);
        chk("s1_we_count", we_cnt, 24);
        chk("s1_seq_err", int'(err_a), 0);

        // Arithmetic corners across the three scale/shift configurations.
        run_image(0, 2, -1, 1'b0, 24);
        chk("s2_in0", mem1[0], -128);
        chk("s2_in128", mem1[8], 0);
        chk("s2_in255", mem1[16], 127);
        chk("s2_scale4_in200", mem4[1], 127);
        chk("s2_scale4_in20", mem4[9], -128);
        chk("s2_scale3_shift2_in140", mem3[17], 9);

        // Alternating in_we.
        run_image(1, 0, -1, 1'b0, 24);
        chk("s3_we_count", we_cnt, 24);
        chk("s3_addr9_data", mem1[9], -124);

        // Address skip 5 -> 7.
        run_image(0, 0, 6, 1'b0, 24);
        chk("s4_seq_err_sticky", int'(err_a), 1);
        chk("s4_we_count", we_cnt, 24);

        // Reset mid-image.
        run_image(0, 1, -1, 1'b0, 10);
        rst = 1'b0;
        #1;
        chk("s5_rst_out_we", int'(ow_a), 0);
        chk("s5_rst_busy", int'(busy_a), 0);
        chk("s5_rst_err", int'(err_a), 0);
        repeat (4) tick;
        rst = 1'b1;
        repeat (4) tick;
        chk("s5_no_done", done_cnt, 0);
        run_image(0, 0, -1, 1'b0, 24);
        chk("s5_addr9_data", mem1[9], -124);
        chk("s5_we_count", we_cnt, 24);

        // in_we in IDLE (also coincident with start), then a byte during DRAIN.
        in_we = 1'b1; in_data = 8'd5; in_addr = 20'd0;
        repeat (2) tick;
        run_image(0, 0, -1, 1'b1, 24);
        chk("s6_drain_byte_err", int'(err_a), 1);
        chk("s6_we_count", we_cnt, 24);

        // Random data with random gaps.
        for (int r = 0; r < 3; r++) begin
            run_image(2, 1, -1, 1'b0, 24);
            chk("rand_we_count", we_cnt, 24);
            chk("rand_done_count", done_cnt, 1);
        end

        repeat (3) tick;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
